alu_unit: RTL and testbench

- 32-bit RV32I integer ALU for the single-cycle core's execute stage.
- Computes one of ten arithmetic, logic, compare or shift operations on two operands, selected by a 4-bit opcode.
- The result is available combinationally (same-cycle writeback path) and as a registered copy for pipelined or debug consumers.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_shifter.sv | 51 +++++
 rtl/alu_unit.sv | 104 ++++++++++
 tb/tb_alu_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and widths for the RV32I ALU and its shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLTU = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_PASS = 2'b11
  } shift_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module   : alu_shifter
// Purpose  : 5-stage barrel shifter (SLL / SRL / SRA / pass-through).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_type,
  output logic [XLEN-1:0]    o_result
);

  logic [XLEN-1:0]          data_in;
  logic [SHAMT_W-1:0]       shamt_eff;
  logic                     fill;
  logic [SHAMT_W:0][XLEN-1:0] stage;
  logic                     is_left;

  assign is_left   = (i_type == SH_SLL);
  assign shamt_eff = (i_type == SH_PASS) ? '0 : i_shamt;
  assign fill      = (i_type == SH_SRA) & i_data[XLEN-1];

  // Left shifts reuse the right-shift network by mirroring the word in and out.
  always_comb begin
    data_in = i_data;
    if (is_left) begin
      for (int k = 0; k < XLEN; k++) data_in[k] = i_data[XLEN-1-k];
    end
  end

  assign stage[0] = data_in;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign stage[i+1] = shamt_eff[i] ? {{SH{fill}}, stage[i][XLEN-1:SH]} : stage[i];
  end

  always_comb begin
    o_result = stage[SHAMT_W];
    if (is_left) begin
      for (int k = 0; k < XLEN; k++) o_result[k] = stage[SHAMT_W][XLEN-1-k];
    end
  end

endmodule : alu_shifter

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
// Module   : alu_unit
// Purpose  : RV32I integer ALU, combinational result plus registered copy.
//            Optional sticky illegal-opcode flag: ALU_ILLEGAL_OP_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_unit
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_data,
  output logic            alu_zero,
  output logic [XLEN-1:0] alu_data_q
`ifdef ALU_ILLEGAL_OP_FLAG_EN
  ,
  output logic            o_illegal_op
`endif
);

  logic            is_add;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic            overflow;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [1:0]      shift_type;
  logic [XLEN-1:0] shift_res;
  logic            op_legal;
  logic [XLEN-1:0] alu_data_d;

  // One adder serves ADD, SUB and both compares; anything but ADD subtracts.
  assign is_add = (alu_op == ALU_ADD);
  assign b_eff  = is_add ? operand_b : ~operand_b;
  assign sum    = {1'b0, operand_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, ~is_add};

  assign overflow    = (operand_a[XLEN-1] ^ operand_b[XLEN-1]) & (sum[XLEN-1] ^ operand_a[XLEN-1]);
  assign lt_signed   = sum[XLEN-1] ^ overflow;
  assign lt_unsigned = ~sum[XLEN];

  always_comb begin
    case (alu_op)
      ALU_SLL: shift_type = SH_SLL;
      ALU_SRL: shift_type = SH_SRL;
      ALU_SRA: shift_type = SH_SRA;
      default: shift_type = SH_PASS;
    endcase
  end

  alu_shifter u_shifter (
    .i_data   (operand_a),
    .i_shamt  (operand_b[SHAMT_W-1:0]),
    .i_type   (shift_type),
    .o_result (shift_res)
  );

  always_comb begin
    alu_data = '0;
    op_legal = 1'b1;
    case (alu_op)
      ALU_ADD, ALU_SUB:          alu_data = sum[XLEN-1:0];
      ALU_SLTU:                  alu_data = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_SLT:                   alu_data = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_data = shift_res;
      ALU_AND:                   alu_data = operand_a & operand_b;
      ALU_OR:                    alu_data = operand_a | operand_b;
      ALU_XOR:                   alu_data = operand_a ^ operand_b;
      default:                   op_legal = 1'b0;
    endcase
  end

  assign alu_zero   = (alu_data == '0);
  assign alu_data_d = alu_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) alu_data_q <= '0;
    else       alu_data_q <= alu_data_d;
  end

`ifdef ALU_ILLEGAL_OP_FLAG_EN
  logic illegal_op_d;
  logic illegal_op_q;

  assign illegal_op_d = illegal_op_q | ~op_legal;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) illegal_op_q <= 1'b0;
    else       illegal_op_q <= illegal_op_d;
  end

  assign o_illegal_op = illegal_op_q;
`else
  logic unused_legal;
  assign unused_legal = op_legal;
`endif

endmodule : alu_unit

`default_nettype wire

// File: tb/tb_alu_unit.sv
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Directed vector table, register timing sequence and random sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [3:0]  alu_op = '0;
  logic [31:0] alu_data;
  logic        alu_zero;
  logic [31:0] alu_data_q;
`ifdef ALU_ILLEGAL_OP_FLAG_EN
  logic        o_illegal_op;
`endif

  int n_total = 0;
  int n_pass  = 0;

  alu_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_op     (alu_op),
    .alu_data   (alu_data),
    .alu_zero   (alu_zero),
    .alu_data_q (alu_data_q)
`ifdef ALU_ILLEGAL_OP_FLAG_EN
    ,
    .o_illegal_op (o_illegal_op)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return (a < b) ? 32'd1 : 32'd0;
      4'b0011: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return 32'($signed(a) >>> b[4:0]);
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  vec_t vecs[20];
  logic [3:0] legal_ops[10];

  initial begin
    vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[2]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[3]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[4]  = '{4'b0011, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    vecs[5]  = '{4'b0010, 32'h7FFFFFFF, 32'h80000000, 32'h00000001};
    vecs[6]  = '{4'b0011, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    vecs[7]  = '{4'b0110, 32'h80000000, 32'h00000004, 32'hF8000000};
    vecs[8]  = '{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000};
    vecs[9]  = '{4'b0100, 32'h00000001, 32'h00000021, 32'h00000002};
    vecs[10] = '{4'b0100, 32'h12345678, 32'hFFFFFFE0, 32'h12345678};
    vecs[11] = '{4'b0110, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
    vecs[12] = '{4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001};
    vecs[13] = '{4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[14] = '{4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    vecs[15] = '{4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[16] = '{4'b1111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000};
    vecs[17] = '{4'b0111, 32'h00000005, 32'h00000005, 32'h00000000};
    vecs[18] = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000};
    vecs[19] = '{4'b0000, 32'h12345678, 32'h11111111, 32'h23456789};
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                  4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010};

    // Reset state
    #2;
    check("reset_q", alu_data_q, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed table: combinational result, zero flag, then registered copy
    foreach (vecs[i]) begin
      @(negedge i_clk);
      alu_op    = vecs[i].op;
      operand_a = vecs[i].a;
      operand_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_data", i), alu_data, vecs[i].exp);
      check($sformatf("vec%0d_zero", i), {31'd0, alu_zero}, {31'd0, vecs[i].exp == 32'h0});
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d_q", i), alu_data_q, vecs[i].exp);
    end

    // Register timing: async reset mid-cycle, then first capture after release
    @(negedge i_clk);
    alu_op = 4'b0000; operand_a = 32'd1; operand_b = 32'd1;
    @(posedge i_clk);
    #1;
    check("pre_rst_q", alu_data_q, 32'd2);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_q", alu_data_q, 32'd0);
    check("rst_comb_data", alu_data, 32'd2);
    @(negedge i_clk);
    i_rst = 1'b0;
    operand_a = 32'd3; operand_b = 32'd4;
    #1;
    check("add34_comb", alu_data, 32'd7);
    check("add34_q_before_edge", alu_data_q, 32'd0);
    @(posedge i_clk);
    #1;
    check("add34_q_after_edge", alu_data_q, 32'd7);

`ifdef ALU_ILLEGAL_OP_FLAG_EN
    check("illegal_after_rst", {31'd0, o_illegal_op}, 32'd0);
    @(negedge i_clk);
    alu_op = 4'b0111;
    #1;
    check("illegal_before_edge", {31'd0, o_illegal_op}, 32'd0);
    @(posedge i_clk);
    #1;
    check("illegal_set", {31'd0, o_illegal_op}, 32'd1);
    @(negedge i_clk);
    alu_op = 4'b0000;
    @(posedge i_clk);
    #1;
    check("illegal_sticky", {31'd0, o_illegal_op}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("illegal_cleared", {31'd0, o_illegal_op}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
`endif

    // Random sweep over every legal opcode
    for (int r = 0; r < 20; r++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (r == 0) rb = ra;
      for (int k = 0; k < 10; k++) begin
        @(negedge i_clk);
        alu_op = legal_ops[k]; operand_a = ra; operand_b = rb;
        #1;
        check($sformatf("rnd%0d_op%0h", r, legal_ops[k]), alu_data, model(legal_ops[k], ra, rb));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_unit

`default_nettype wire
